ticker_feed: RTL and testbench
==============================

TICKER_FEED -- requirements
Module: ticker_feed

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning CLOCK_50 cycles per scroll step (legal range 2 and up).
REQ-002 SHALL have parameter DEPTH, default 8, meaning maximum message length in characters (legal range 3..12).
REQ-003 SHALL have one clock and an asynchronous active-high reset; the clock port is CLOCK_50 and the reset port is reset.
REQ-004 CLOCK_50  in  1  system clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high, clears all state.
REQ-006 wr_en  in  1  append wr_char to the message this cycle.
REQ-007 wr_char  in  2  character code: 00=d, 01=E, 10=1, 11=blank.
REQ-008 clear  in  1  empty the message.
REQ-009 run  in  1  1=scroll, 0=edit/freeze.
REQ-010 chars  out  12  six 2-bit codes for the downstream 7-seg decoders; [11:10]=HEX5 (leftmost) down to [1:0]=HEX0.
REQ-011 len  out  4  current message length.
REQ-012 full  out  1  high when len == DEPTH.
REQ-013 tick  out  1  one-cycle pulse on each scroll step.

Function
REQ-014 Message storage SHALL be DEPTH entries of 2 bits; mem[0] is the first character.
REQ-015 With run=0, wr_en=1, clear=0 and len<DEPTH, the block SHALL write mem[len] <= wr_char and set len <= len+1, with head <= 0, all in the same edge.
REQ-016 wr_en while full, or while run=1, SHALL be ignored: no change to mem, len or head.
REQ-017 clear=1 SHALL set len <= 0 and head <= 0 regardless of run; clear SHALL win over a simultaneous wr_en.
REQ-018 The scroll stream SHALL have period N = len+3: stream[i] = mem[i] for i < len, and stream[i] = 11 (blank) for len <= i < N.
REQ-019 The display position for HEX(5-k), k=0..5, SHALL show stream[(head+k) mod N]; the mod SHALL hold for N < 6, so the window repeats the stream.
REQ-020 chars SHALL be a combinational function of mem, len and head, with no added latency.
REQ-021 When len=0, chars SHALL be 12'hFFF.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only while run=1 and len>0, and SHALL hold at 0 otherwise.
REQ-023 tick SHALL be 1 for exactly the cycle in which the prescaler equals TICK_DIV-1, after which the prescaler wraps to 0.
REQ-024 On tick, head SHALL advance by 1; head == N-1 SHALL wrap to 0.
REQ-025 A scroll step is TICK_DIV cycles after run rises; the first tick SHALL occur on the TICK_DIV-th rising edge with run=1.
REQ-026 While run=0, head SHALL hold, freezing the display.
REQ-027 When clear occurs during run, the prescaler SHALL restart from 0 (because len becomes 0).

Reset
REQ-028 reset SHALL asynchronously set len=0, head=0, prescaler=0, tick=0 and full=0, giving chars=12'hFFF.
REQ-029 mem contents are don't-care after reset and SHALL never be visible, because len=0.
REQ-030 reset asserted mid-scroll SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-031 A shared package ticker_pkg SHALL hold the character code constants (CH_D=00, CH_E=01, CH_1=10, CH_BLANK=11) and the gap length constant (3).
REQ-032 The prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV; inputs CLOCK_50, reset, en; output tick).
REQ-033 The 7-seg decode is NOT part of this block; chars feeds six existing decoder instances.

Verification (TICK_DIV=4, DEPTH=8)
REQ-034 Reset, then write d,E,1 with run=0 -> len=3, full=0, head=0, chars = 00_01_10_11_11_11.
REQ-035 Load as in REQ-034, set run=1 and hold 24 cycles -> tick every 4th cycle; after tick 1 chars = 01_10_11_11_11_00; after tick 6 head=0 with the original pattern.
REQ-036 Write 9 characters with run=0 -> len stops at 8, full=1 from the 8th write, 9th write ignored; then wr_en with run=1 -> no change.
REQ-037 Apply clear and wr_en together mid-scroll -> len=0, head=0, chars=12'hFFF, tick stays 0 while len=0.
REQ-038 Load one character 10 with run=1 (N=4) -> chars = 10_11_11_11_10_11; the window wraps and head cycles 0..3.
REQ-039 Assert reset asynchronously between clock edges during scroll -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/ticker_pkg.sv
// Shared character codes and gap length for the scrolling ticker display.
// The codes match the inputs of the existing 7-seg decoder instances.
package ticker_pkg;

    typedef logic [1:0] char_t;

    localparam char_t CH_D     = 2'b00;
    localparam char_t CH_E     = 2'b01;
    localparam char_t CH_1     = 2'b10;
    localparam char_t CH_BLANK = 2'b11;

    localparam int GAP_LEN   = 3;
    localparam int NUM_DIGITS = 6;

endpackage

// File: rtl/ticker_feed_tick_gen.sv
// Scroll-step prescaler: counts CLOCK_50 cycles while enabled and pulses tick
// on the last count of every TICK_DIV-cycle period.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Gating with en keeps a stale terminal count from stepping a frozen display.
    assign tick = en && (count == LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ticker_feed.sv
// Message buffer and scroll window for a six-digit 7-seg ticker. Characters are
// appended while frozen; while running the message plus a blank gap scrolls left.
module ticker_feed
    import ticker_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DEPTH    = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_char,
    input  logic        clear,
    input  logic        run,
    output logic [11:0] chars,
    output logic [3:0]  len,
    output logic        full,
    output logic        tick
);

    char_t      mem [DEPTH];
    logic [3:0] head;
    logic [3:0] last_pos;
    logic       do_write;
    logic       scroll_en;
    logic [3:0] pos;
    char_t      sym;

    assign last_pos  = len + 4'(GAP_LEN - 1);
    assign full      = (len == 4'(DEPTH));
    assign do_write  = wr_en && !clear && !run && !full;
    assign scroll_en = run && (len != 4'd0);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .en      (scroll_en),
        .tick    (tick)
    );

    // Storage needs no reset: entries at or beyond len are never displayed.
    always_ff @(posedge CLOCK_50) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (do_write && len == 4'(j)) begin
                mem[j] <= wr_char;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            len  <= 4'd0;
            head <= 4'd0;
        end else if (clear) begin
            len  <= 4'd0;
            head <= 4'd0;
        end else if (do_write) begin
            len  <= len + 4'd1;
            head <= 4'd0;
        end else if (tick) begin
            head <= (head == last_pos) ? 4'd0 : head + 4'd1;
        end
    end

    // Walk the stream from head, wrapping at len+GAP_LEN so short messages repeat.
    always_comb begin
        chars = '1;
        pos   = head;
        sym   = CH_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sym = CH_BLANK;
            for (int j = 0; j < DEPTH; j++) begin
                if (pos == 4'(j) && pos < len) begin
                    sym = mem[j];
                end
            end
            chars[11 - 2*k -: 2] = sym;
            pos = (pos == last_pos) ? 4'd0 : pos + 4'd1;
        end
    end

endmodule

// File: tb/tb_ticker_feed.sv
// Self-checking bench for ticker_feed with TICK_DIV=4, DEPTH=8: a behavioural
// model predicts outputs each cycle and a queue carries them to the checker.
module tb_ticker_feed;
    import ticker_pkg::*;

    localparam int TD = 4;
    localparam int D  = 8;

    logic        CLOCK_50;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_char;
    logic        clear;
    logic        run;
    logic [11:0] chars;
    logic [3:0]  len;
    logic        full;
    logic        tick;

    typedef struct {
        logic        tick;
        logic [11:0] chars;
        logic [3:0]  len;
        logic        full;
    } expect_t;

    expect_t exp_q[$];

    logic [1:0] m_mem [D];
    int m_len, m_head, m_cnt;
    int errors = 0;
    int checks = 0;

    ticker_feed #(
        .TICK_DIV(TD),
        .DEPTH   (D)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_char (wr_char),
        .clear   (clear),
        .run     (run),
        .chars   (chars),
        .len     (len),
        .full    (full),
        .tick    (tick)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Window of six positions over stream = message followed by three blanks.
    function automatic logic [11:0] modelChars();
        logic [11:0] r;
        int i;
        r = 12'hFFF;
        for (int k = 0; k < 6; k++) begin
            i = (m_head + k) % (m_len + 3);
            r[11 - 2*k -: 2] = (i < m_len) ? m_mem[i] : 2'b11;
        end
        return r;
    endfunction

    function automatic void modelReset();
        m_len  = 0;
        m_head = 0;
        m_cnt  = 0;
    endfunction

    // Predicted outputs for the current (pre-edge) state and driven inputs.
    function automatic void pushExpect(input logic r);
        expect_t e;
        e.tick  = r && (m_len > 0) && (m_cnt == TD - 1);
        e.chars = modelChars();
        e.len   = 4'(m_len);
        e.full  = (m_len == D);
        exp_q.push_back(e);
    endfunction

    function automatic void modelEdge(input logic w, input logic [1:0] c,
                                      input logic cl, input logic r);
        logic tk;
        int old_len;
        old_len = m_len;
        tk = r && (m_len > 0) && (m_cnt == TD - 1);
        if (cl) begin
            m_len  = 0;
            m_head = 0;
        end else if (w && !r && m_len < D) begin
            m_mem[m_len] = c;
            m_len  = m_len + 1;
            m_head = 0;
        end else if (tk) begin
            m_head = (m_head + 1) % (old_len + 3);
        end
        m_cnt = (r && old_len > 0) ? (m_cnt + 1) % TD : 0;
    endfunction

    task automatic checkOutput(input string tag);
        expect_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s: scoreboard empty, observed chars=%h expected an entry", tag, chars);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (tick === e.tick) else begin
                errors++;
                $error("[TB] FAIL %s.tick: observed=%b expected=%b", tag, tick, e.tick);
            end
            checks++;
            assert (chars === e.chars) else begin
                errors++;
                $error("[TB] FAIL %s.chars: observed=%h expected=%h", tag, chars, e.chars);
            end
            checks++;
            assert (len === e.len) else begin
                errors++;
                $error("[TB] FAIL %s.len: observed=%0d expected=%0d", tag, len, e.len);
            end
            checks++;
            assert (full === e.full) else begin
                errors++;
                $error("[TB] FAIL %s.full: observed=%b expected=%b", tag, full, e.full);
            end
        end
    endtask

    task automatic checkDirect(input string tag, input logic [11:0] obs, input logic [11:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then step the model.
    task automatic applyStimulus(input logic w, input logic [1:0] c,
                                 input logic cl, input logic r, input string tag);
        wr_en   = w;
        wr_char = c;
        clear   = cl;
        run     = r;
        #3;
        pushExpect(r);
        checkOutput(tag);
        @(posedge CLOCK_50);
        #1;
        modelEdge(w, c, cl, r);
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_char = CH_D;
        clear   = 1'b0;
        run     = 1'b0;
        modelReset();
        repeat (2) @(posedge CLOCK_50);
        #2;
        pushExpect(1'b0);
        checkOutput("reset");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;

        $display("[TB] loading d,E,1 while frozen");
        applyStimulus(1'b1, CH_D, 1'b0, 1'b0, "wr_d");
        applyStimulus(1'b1, CH_E, 1'b0, 1'b0, "wr_e");
        applyStimulus(1'b1, CH_1, 1'b0, 1'b0, "wr_1");
        applyStimulus(1'b0, CH_D, 1'b0, 1'b0, "idle");
        checkDirect("load3_chars", chars, 12'h1BF);
        checkDirect("load3_len", {8'd0, len}, 12'd3);

        $display("[TB] scrolling 24 cycles");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "scroll3");
            if (i == 3) checkDirect("after_tick1", chars, 12'h6FC);
        end
        checkDirect("after_tick6", chars, 12'h1BF);

        $display("[TB] clear with write mid-scroll");
        applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "prescroll");
        applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "prescroll");
        applyStimulus(1'b1, CH_E, 1'b1, 1'b1, "clear_wr");
        checkDirect("clear_chars", chars, 12'hFFF);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "empty_run");
        end

        $display("[TB] filling beyond depth");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 2'(i % 4), 1'b0, 1'b0, "fill");
            if (i == 7) checkDirect("full_at_8", {11'd0, full}, 12'd1);
        end
        checkDirect("len_capped", {8'd0, len}, 12'd8);
        applyStimulus(1'b1, CH_D, 1'b0, 1'b1, "wr_while_run");
        checkDirect("len_run_wr", {8'd0, len}, 12'd8);
        applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "run_full");

        $display("[TB] single character wrap");
        applyStimulus(1'b0, CH_D, 1'b1, 1'b0, "clear");
        applyStimulus(1'b1, CH_1, 1'b0, 1'b0, "wr_one");
        checkDirect("one_char", chars, 12'hBFB);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "scroll1");
        end
        checkDirect("one_char_wrap", chars, 12'hBFB);
        applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "scroll1");
        applyStimulus(1'b0, CH_D, 1'b0, 1'b1, "scroll1");

        $display("[TB] asynchronous reset mid-scroll");
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        pushExpect(1'b1);
        checkOutput("async_reset");
        checkDirect("async_chars", chars, 12'hFFF);
        run = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, CH_D, 1'b0, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
